// File: rtl/bank_burst_sequencer_if.sv
// ---------------------------------------------------------------------------
// bank_burst_sequencer_if
// Host-side request / write-data / read-data bundle for bank_burst_sequencer.
//   req_valid/req_ready  : burst request handshake (ready only while idle)
//   req_wr/bg/ba/row/col : burst type and target address
//   wdata_valid/wdata/wdata_ready : write beat stream
//   rdata_valid/rdata    : read beat return
//   busy                 : burst in progress
// Modports: master = host side, slave = sequencer side.
// ---------------------------------------------------------------------------
interface bank_burst_sequencer_if #(
    parameter int BGWIDTH      = 2,
    parameter int BAWIDTH      = 2,
    parameter int COLWIDTH     = 10,
    parameter int CHWIDTH      = 5,
    parameter int DEVICE_WIDTH = 4
) ();
    logic                    req_valid;
    logic                    req_ready;
    logic                    req_wr;
    logic [BGWIDTH-1:0]      req_bg;
    logic [BAWIDTH-1:0]      req_ba;
    logic [CHWIDTH-1:0]      req_row;
    logic [COLWIDTH-1:0]     req_col;
    logic                    wdata_valid;
    logic [DEVICE_WIDTH-1:0] wdata;
    logic                    wdata_ready;
    logic                    rdata_valid;
    logic [DEVICE_WIDTH-1:0] rdata;
    logic                    busy;

    modport master (
        output req_valid, req_wr, req_bg, req_ba, req_row, req_col,
        output wdata_valid, wdata,
        input  req_ready, wdata_ready, rdata_valid, rdata, busy
    );

    modport slave (
        input  req_valid, req_wr, req_bg, req_ba, req_row, req_col,
        input  wdata_valid, wdata,
        output req_ready, wdata_ready, rdata_valid, rdata, busy
    );
endinterface

// File: rtl/bank_burst_sequencer.sv
// ---------------------------------------------------------------------------
// bank_burst_sequencer
// Turns one burst request (read or write, BL beats) into per-beat accesses on
// a banked chip model. Beat columns wrap inside the BL-aligned column block.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   bus         : bank_burst_sequencer_if.slave (request / wdata / rdata / busy)
//   rd_o_wr, row, column, dqin : registered per-bank chip drive, zero when idle
//   dqout       : per-bank chip read data (sampled one cycle after issue)
//   wr_bursts, rd_bursts : completed burst counters, only with BURST_STATS_EN
// Optional feature macro: BURST_STATS_EN
// ---------------------------------------------------------------------------
module bank_burst_sequencer #(
    parameter int  BGWIDTH       = 2,
    parameter int  BAWIDTH       = 2,
    parameter int  COLWIDTH      = 10,
    parameter int  CHWIDTH       = 5,
    parameter int  DEVICE_WIDTH  = 4,
    parameter int  BL            = 8,
    localparam int BANKGROUPS    = 2**BGWIDTH,
    localparam int BANKSPERGROUP = 2**BAWIDTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    bank_burst_sequencer_if.slave   bus,
    output logic                    rd_o_wr [BANKGROUPS-1:0][BANKSPERGROUP-1:0],
    output logic [CHWIDTH-1:0]      row     [BANKGROUPS-1:0][BANKSPERGROUP-1:0],
    output logic [COLWIDTH-1:0]     column  [BANKGROUPS-1:0][BANKSPERGROUP-1:0],
    output logic [DEVICE_WIDTH-1:0] dqin    [BANKGROUPS-1:0][BANKSPERGROUP-1:0],
    input  logic [DEVICE_WIDTH-1:0] dqout   [BANKGROUPS-1:0][BANKSPERGROUP-1:0]
`ifdef BURST_STATS_EN
    ,
    output logic [15:0]             wr_bursts,
    output logic [15:0]             rd_bursts
`endif
);

    typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

    localparam int                   BEATW     = (BL > 1) ? $clog2(BL) : 1;
    localparam logic [BEATW-1:0]     LAST_BEAT = BEATW'(BL - 1);
    localparam logic [COLWIDTH-1:0]  LOWMASK   = COLWIDTH'(BL - 1);

    // Upper column bits are kept, the low log2(BL) bits wrap modulo BL.
    function automatic logic [COLWIDTH-1:0] beat_col(input logic [COLWIDTH-1:0] base,
                                                     input logic [BEATW-1:0]    beat);
        logic [COLWIDTH-1:0] sum;
        sum = base + COLWIDTH'(beat);
        return (base & ~LOWMASK) | (sum & LOWMASK);
    endfunction

    state_t              state_q, state_d;
    logic [BEATW-1:0]    beat_q, beat_d;
    logic [BGWIDTH-1:0]  bg_q, bg_d;
    logic [BAWIDTH-1:0]  ba_q, ba_d;
    logic [CHWIDTH-1:0]  row_q, row_d;
    logic [COLWIDTH-1:0] col_q, col_d;

    // Next-cycle drive for the single selected bank; decoded into the arrays
    // at the register stage so every chip pin comes straight from a flop.
    logic                    pin_en_d;
    logic                    pin_wr_d;
    logic [BGWIDTH-1:0]      pin_bg_d;
    logic [BAWIDTH-1:0]      pin_ba_d;
    logic [CHWIDTH-1:0]      pin_row_d;
    logic [COLWIDTH-1:0]     pin_col_d;
    logic [DEVICE_WIDTH-1:0] pin_dq_d;

    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        bg_d      = bg_q;
        ba_d      = ba_q;
        row_d     = row_q;
        col_d     = col_q;
        pin_en_d  = 1'b0;
        pin_wr_d  = 1'b0;
        pin_bg_d  = bg_q;
        pin_ba_d  = ba_q;
        pin_row_d = row_q;
        pin_col_d = '0;
        pin_dq_d  = '0;
        unique case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    bg_d   = bus.req_bg;
                    ba_d   = bus.req_ba;
                    row_d  = bus.req_row;
                    col_d  = bus.req_col;
                    beat_d = '0;
                    if (bus.req_wr) begin
                        state_d = WRITE;
                    end else begin
                        // Read beat 0 is put on the pins as READ is entered so
                        // each READ cycle carries its own beat address.
                        state_d   = READ;
                        pin_en_d  = 1'b1;
                        pin_bg_d  = bus.req_bg;
                        pin_ba_d  = bus.req_ba;
                        pin_row_d = bus.req_row;
                        pin_col_d = beat_col(bus.req_col, '0);
                    end
                end
            end
            WRITE: begin
                if (bus.wdata_valid) begin
                    pin_en_d  = 1'b1;
                    pin_wr_d  = 1'b1;
                    pin_col_d = beat_col(col_q, beat_q);
                    pin_dq_d  = bus.wdata;
                    beat_d    = beat_q + 1'b1;
                    if (beat_q == LAST_BEAT) state_d = IDLE;
                end
            end
            READ: begin
                if (beat_q == LAST_BEAT) begin
                    state_d = DRAIN;
                end else begin
                    beat_d    = beat_q + 1'b1;
                    pin_en_d  = 1'b1;
                    pin_col_d = beat_col(col_q, beat_q + 1'b1);
                end
            end
            DRAIN:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            beat_q          <= '0;
            bg_q            <= '0;
            ba_q            <= '0;
            row_q           <= '0;
            col_q           <= '0;
            bus.req_ready   <= 1'b1;
            bus.busy        <= 1'b0;
            bus.wdata_ready <= 1'b0;
            bus.rdata_valid <= 1'b0;
            bus.rdata       <= '0;
            for (int unsigned g = 0; g < BANKGROUPS; g++) begin
                for (int unsigned b = 0; b < BANKSPERGROUP; b++) begin
                    rd_o_wr[g][b] <= 1'b0;
                    row[g][b]     <= '0;
                    column[g][b]  <= '0;
                    dqin[g][b]    <= '0;
                end
            end
        end else begin
            state_q         <= state_d;
            beat_q          <= beat_d;
            bg_q            <= bg_d;
            ba_q            <= ba_d;
            row_q           <= row_d;
            col_q           <= col_d;
            bus.req_ready   <= (state_d == IDLE);
            bus.busy        <= (state_d != IDLE);
            bus.wdata_ready <= (state_d == WRITE);
            // Chip answers during the cycle the beat sits on the pins.
            bus.rdata_valid <= (state_q == READ);
            bus.rdata       <= (state_q == READ) ? dqout[bg_q][ba_q] : '0;
            for (int unsigned g = 0; g < BANKGROUPS; g++) begin
                for (int unsigned b = 0; b < BANKSPERGROUP; b++) begin
                    if (pin_en_d && pin_bg_d == BGWIDTH'(g) && pin_ba_d == BAWIDTH'(b)) begin
                        rd_o_wr[g][b] <= pin_wr_d;
                        row[g][b]     <= pin_row_d;
                        column[g][b]  <= pin_col_d;
                        dqin[g][b]    <= pin_dq_d;
                    end else begin
                        rd_o_wr[g][b] <= 1'b0;
                        row[g][b]     <= '0;
                        column[g][b]  <= '0;
                        dqin[g][b]    <= '0;
                    end
                end
            end
        end
    end

`ifdef BURST_STATS_EN
    logic [15:0] wr_cnt_q;
    logic [15:0] rd_cnt_q;

    // A read only counts once its last beat has returned (DRAIN), so a reset
    // anywhere inside the burst leaves it uncounted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
        end else begin
            if (state_q == WRITE && bus.wdata_valid && beat_q == LAST_BEAT && wr_cnt_q != '1)
                wr_cnt_q <= wr_cnt_q + 16'd1;
            if (state_q == DRAIN && rd_cnt_q != '1)
                rd_cnt_q <= rd_cnt_q + 16'd1;
        end
    end

    assign wr_bursts = wr_cnt_q;
    assign rd_bursts = rd_cnt_q;
`endif

endmodule

// File: tb/tb_bank_burst_sequencer.sv
// ---------------------------------------------------------------------------
// tb_bank_burst_sequencer
// Randomized + directed bench. A behavioural chip (associative memory per
// bank) sits on the chip-side ports; a separate reference memory records what
// each write burst should have stored, addressed by the wrapping column rule.
// ---------------------------------------------------------------------------
module tb_bank_burst_sequencer;
    localparam int NG = 4;
    localparam int NB = 4;
    localparam int BL = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    bank_burst_sequencer_if #(.BGWIDTH(2), .BAWIDTH(2), .COLWIDTH(10), .CHWIDTH(5),
                              .DEVICE_WIDTH(4)) bus ();

    logic       rd_o_wr [NG-1:0][NB-1:0];
    logic [4:0] row     [NG-1:0][NB-1:0];
    logic [9:0] column  [NG-1:0][NB-1:0];
    logic [3:0] dqin    [NG-1:0][NB-1:0];
    logic [3:0] dqout   [NG-1:0][NB-1:0];
`ifdef BURST_STATS_EN
    logic [15:0] wr_bursts;
    logic [15:0] rd_bursts;
`endif

    bank_burst_sequencer #(
        .BGWIDTH(2), .BAWIDTH(2), .COLWIDTH(10), .CHWIDTH(5), .DEVICE_WIDTH(4), .BL(BL)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus),
        .rd_o_wr(rd_o_wr),
        .row(row),
        .column(column),
        .dqin(dqin),
        .dqout(dqout)
`ifdef BURST_STATS_EN
        ,
        .wr_bursts(wr_bursts),
        .rd_bursts(rd_bursts)
`endif
    );

    int n_vec = 0;
    int n_err = 0;
    int exp_wr = 0;
    int exp_rd = 0;

    logic [3:0] chip_mem [int];
    logic [3:0] ref_mem  [int];

    function automatic int key(int g, int b, int r, int c);
        return (g << 17) | (b << 15) | (r << 10) | c;
    endfunction

    // Column of beat i: BL-aligned block base plus wrapped offset.
    function automatic int ecol(int col, int i);
        return (col / BL) * BL + ((col % BL) + i) % BL;
    endfunction

    function automatic int ref_rd(int k);
        return ref_mem.exists(k) ? int'(ref_mem[k]) : 0;
    endfunction

    function automatic int bank_active(int g, int b);
        return (rd_o_wr[g][b] || row[g][b] != 0 || column[g][b] != 0 || dqin[g][b] != 0) ? 1 : 0;
    endfunction

    function automatic int others_active(int sg, int sb);
        int n = 0;
        for (int g = 0; g < NG; g++)
            for (int b = 0; b < NB; b++)
                if (!(g == sg && b == sb)) n += bank_active(g, b);
        return n;
    endfunction

    function automatic int all_active();
        int n = 0;
        for (int g = 0; g < NG; g++)
            for (int b = 0; b < NB; b++) n += bank_active(g, b);
        return n;
    endfunction

    // Chip model: stores on write pins, presents read data for the pins of
    // the current cycle well before the next rising edge.
    always @(posedge clk) begin
        for (int g = 0; g < NG; g++)
            for (int b = 0; b < NB; b++)
                if (rd_o_wr[g][b]) chip_mem[key(g, b, row[g][b], column[g][b])] = dqin[g][b];
    end

    always @(negedge clk) begin
        for (int g = 0; g < NG; g++)
            for (int b = 0; b < NB; b++) begin
                int k;
                k = key(g, b, row[g][b], column[g][b]);
                dqout[g][b] = chip_mem.exists(k) ? chip_mem[k] : 4'h0;
            end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic junk_req();
        bus.req_wr  = 1'($urandom);
        bus.req_bg  = 2'($urandom);
        bus.req_ba  = 2'($urandom);
        bus.req_row = 5'($urandom);
        bus.req_col = 10'($urandom);
    endtask

    // Called and returns at a negedge.
    task automatic do_write(input int bg, input int ba, input int r, input int c,
                            input int stall_mask, input bit noise);
        logic [3:0] d [BL];
        bit         stalled [BL];
        int  i = 0, cyc = 0, wr_cycles = 0, oth = 0, prev_beat = 0;
        bit  have_prev = 0, prev_valid = 0, valid;
        for (int k = 0; k < BL; k++) begin
            d[k] = 4'($urandom);
            stalled[k] = 0;
        end
        check("wr_req_ready", bus.req_ready, 1);
        bus.req_valid = 1'b1;
        bus.req_wr    = 1'b1;
        bus.req_bg    = 2'(bg);
        bus.req_ba    = 2'(ba);
        bus.req_row   = 5'(r);
        bus.req_col   = 10'(c);
        @(negedge clk);
        if (noise) junk_req(); else bus.req_valid = 1'b0;
        check("wr_busy", bus.busy, 1);
        check("wr_ready_low", bus.req_ready, 0);
        forever begin
            if (have_prev) begin
                if (prev_valid) begin
                    check("wr_we", rd_o_wr[bg][ba], 1);
                    check("wr_row", row[bg][ba], r);
                    check("wr_col", column[bg][ba], ecol(c, prev_beat));
                    check("wr_dq", dqin[bg][ba], d[prev_beat]);
                end else begin
                    check("wr_stall_we", rd_o_wr[bg][ba], 0);
                end
                oth += others_active(bg, ba);
            end
            if (i == BL) break;
            if (cyc >= 40) begin
                check("wr_timeout", 0, 1);
                break;
            end
            if (bus.wdata_ready) wr_cycles++;
            valid = !(stall_mask[i] && !stalled[i]);
            if (!valid) stalled[i] = 1;
            bus.wdata_valid = valid;
            bus.wdata       = valid ? d[i] : 4'($urandom);
            prev_valid = valid;
            prev_beat  = i;
            have_prev  = 1;
            if (valid) i++;
            cyc++;
            @(negedge clk);
        end
        bus.wdata_valid = 1'b0;
        bus.req_valid   = 1'b0;
        check("wr_done_busy", bus.busy, 0);
        check("wr_done_ready", bus.req_ready, 1);
        check("wr_done_wready", bus.wdata_ready, 0);
        check("wr_cycles", wr_cycles, BL + $countones(stall_mask & 32'hFF));
        check("wr_other_banks", oth, 0);
        for (int k = 0; k < BL; k++) ref_mem[key(bg, ba, r, ecol(c, k))] = d[k];
        exp_wr++;
    endtask

    // abort_at >= 0 pulls reset while beat abort_at is on the pins.
    task automatic do_read(input int bg, input int ba, input int r, input int c,
                           input bit noise, input int abort_at);
        int oth = 0;
        check("rd_req_ready", bus.req_ready, 1);
        bus.req_valid = 1'b1;
        bus.req_wr    = 1'b0;
        bus.req_bg    = 2'(bg);
        bus.req_ba    = 2'(ba);
        bus.req_row   = 5'(r);
        bus.req_col   = 10'(c);
        @(negedge clk);
        if (noise) junk_req(); else bus.req_valid = 1'b0;
        for (int k = 0; k <= BL; k++) begin
            if (k == abort_at) begin
                #2 rst_n = 1'b0;
                bus.req_valid = 1'b0;
                #1;
                check("rst_pins", all_active(), 0);
                check("rst_rvalid", bus.rdata_valid, 0);
                check("rst_rdata", bus.rdata, 0);
                check("rst_busy", bus.busy, 0);
                check("rst_ready", bus.req_ready, 1);
                check("rst_wready", bus.wdata_ready, 0);
                @(negedge clk);
                check("rst_rvalid_hold", bus.rdata_valid, 0);
                rst_n = 1'b1;
                return;
            end
            check("rd_busy", bus.busy, 1);
            if (k < BL) begin
                check("rd_we", rd_o_wr[bg][ba], 0);
                check("rd_row", row[bg][ba], r);
                check("rd_col", column[bg][ba], ecol(c, k));
            end else begin
                check("drain_pins", bank_active(bg, ba), 0);
            end
            check("rd_rvalid", bus.rdata_valid, (k > 0) ? 1 : 0);
            if (k > 0) check("rd_data", bus.rdata, ref_rd(key(bg, ba, r, ecol(c, k - 1))));
            oth += others_active(bg, ba);
            if (k == BL) bus.req_valid = 1'b0;
            @(negedge clk);
        end
        check("rd_end_rvalid", bus.rdata_valid, 0);
        check("rd_end_busy", bus.busy, 0);
        check("rd_end_ready", bus.req_ready, 1);
        check("rd_end_pins", all_active(), 0);
        check("rd_other_banks", oth, 0);
        exp_rd++;
    endtask

    initial begin
        int bg, ba, r, c, m;
        rst_n           = 1'b0;
        bus.req_valid   = 1'b0;
        bus.req_wr      = 1'b0;
        bus.req_bg      = '0;
        bus.req_ba      = '0;
        bus.req_row     = '0;
        bus.req_col     = '0;
        bus.wdata_valid = 1'b0;
        bus.wdata       = '0;
        repeat (3) @(negedge clk);
        check("reset_ready", bus.req_ready, 1);
        check("reset_busy", bus.busy, 0);
        check("reset_wready", bus.wdata_ready, 0);
        check("reset_rvalid", bus.rdata_valid, 0);
        check("reset_rdata", bus.rdata, 0);
        check("reset_pins", all_active(), 0);
        rst_n = 1'b1;
        @(negedge clk);

        do_write(1, 1, 1, 0, 0, 0);
        do_read(1, 1, 1, 0, 0, -1);
        do_write(2, 3, 7, 5, 0, 0);
        do_read(2, 3, 7, 5, 0, -1);
        do_write(0, 2, 31, 10'h3FD, 0, 1);
        do_read(0, 2, 31, 10'h3FD, 1, -1);
        do_write(3, 0, 4, 100, 32'b0010_0100, 0);
        do_read(3, 0, 4, 100, 0, -1);

        for (int n = 0; n < 16; n++) begin
            bg = $urandom_range(0, NG - 1);
            ba = $urandom_range(0, NB - 1);
            r  = $urandom_range(0, 31);
            c  = $urandom_range(0, 1023);
            m  = ($urandom_range(0, 2) == 0) ? int'($urandom & 32'hFF) : 0;
            do_write(bg, ba, r, c, m, 1'($urandom));
            do_read(bg, ba, r, c, 1'($urandom), -1);
        end

        do_read(1, 1, 1, 0, 0, 3);
        do_write(2, 0, 9, 10'h3F2, 32'b1000_0001, 0);
        do_read(2, 0, 9, 10'h3F2, 0, -1);

`ifdef BURST_STATS_EN
        check("stat_wr", wr_bursts, exp_wr);
        check("stat_rd", rd_bursts, exp_rd);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
